// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: recovers line/frame geometry, locks on two matching frames and
// captures single pixels by active coordinate. `VGA_RX_CHECKSUM_EN adds a per-frame pixel sum.
module vga_rx_monitor #(
  parameter bit          HS_ACTIVE_LOW = 1'b1,
  parameter bit          VS_ACTIVE_LOW = 1'b0,
  parameter int unsigned XW            = 12,
  parameter int unsigned YW            = 11
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vga_hs,
  input  logic          vga_vs,
  input  logic          vga_blank_n,
  input  logic [23:0]   vga_rgb,
  output logic [XW-1:0] h_total,
  output logic [XW-1:0] h_sync,
  output logic [XW-1:0] h_active,
  output logic [YW-1:0] v_total,
  output logic [YW-1:0] v_sync,
  output logic [YW-1:0] v_active,
  output logic          locked,
  output logic [7:0]    lock_err_cnt,
  output logic [15:0]   frame_cnt,
`ifdef VGA_RX_CHECKSUM_EN
  output logic [31:0]   frame_sum,
  output logic          frame_sum_valid,
`endif
  input  logic [XW-1:0] cap_x,
  input  logic [YW-1:0] cap_y,
  input  logic          cap_req,
  output logic          cap_valid,
  output logic [23:0]   cap_data,
  output logic          cap_err
);

  typedef enum logic [1:0] {StSearch, StMeasure, StVerify, StLocked} state_e;

  typedef struct packed {
    logic [XW-1:0] ht;
    logic [XW-1:0] hs;
    logic [XW-1:0] ha;
    logic [YW-1:0] vt;
    logic [YW-1:0] vs;
    logic [YW-1:0] va;
  } geom_t;

  function automatic logic [XW-1:0] inc_x(input logic [XW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [YW-1:0] inc_y(input logic [YW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, hs_p_q, hs_p_d, vs_p_q, vs_p_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          req_q, req_d;
  logic [XW-1:0] req_x_q, req_x_d;
  logic [YW-1:0] req_y_q, req_y_d;
  logic [XW-1:0] hc_q, hc_d, hsc_q, hsc_d, bc_q, bc_d;
  logic [XW-1:0] ht_line_q, ht_line_d, hs_line_q, hs_line_d, ha_line_q, ha_line_d;
  logic [YW-1:0] vc_q, vc_d, vsc_q, vsc_d, ay_q, ay_d;
  logic          line_vs_q, line_vs_d, line_act_q, line_act_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  state_e        state_q, state_d;
  geom_t         stored_q, stored_d, commit_q, commit_d, meas;
  logic          locked_q, locked_d;
  logic [7:0]    lock_err_q, lock_err_d;
  logic          pend_q, pend_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic          cap_valid_q, cap_valid_d, cap_err_q, cap_err_d;
  logic [23:0]   cap_data_q, cap_data_d;
`ifdef VGA_RX_CHECKSUM_EN
  logic [31:0]   sum_q, sum_d, fsum_q, fsum_d, pix_add;
  logic          fsv_q, fsv_d;
`endif

  logic          hs_lead, vs_lead, hit, in_range;
  logic [XW-1:0] cur_ax;
  logic [YW-1:0] vc_n, vsc_n, ay_n, cur_ay;

  assign hs_lead  = hs_q & ~hs_p_q;
  assign vs_lead  = vs_q & ~vs_p_q;
  // Line end is applied before the frame boundary when both edges share a sample.
  assign vc_n     = hs_lead ? inc_y(vc_q) : vc_q;
  assign vsc_n    = (hs_lead && line_vs_q) ? inc_y(vsc_q) : vsc_q;
  assign ay_n     = (hs_lead && line_act_q) ? inc_y(ay_q) : ay_q;
  assign cur_ax   = hs_lead ? '0 : bc_q;
  assign cur_ay   = vs_lead ? '0 : ay_n;
  assign in_range = (cx_q < commit_q.ha) && (cy_q < commit_q.va);
  assign hit      = pend_q && locked_q && blank_q && in_range &&
                    (cur_ax == cx_q) && (cur_ay == cy_q);

  always_comb begin
    meas    = '0;
    meas.ht = hs_lead ? hc_q : ht_line_q;
    meas.hs = hs_lead ? hsc_q : hs_line_q;
    meas.ha = (hs_lead && bc_q != '0) ? bc_q : ha_line_q;
    meas.vt = vc_n;
    meas.vs = vsc_n;
    meas.va = ay_n;
  end

  always_comb begin
    hs_d    = HS_ACTIVE_LOW ? ~vga_hs : vga_hs;
    vs_d    = VS_ACTIVE_LOW ? ~vga_vs : vga_vs;
    blank_d = vga_blank_n;
    rgb_d   = vga_rgb;
    req_d   = cap_req;
    req_x_d = cap_x;
    req_y_d = cap_y;
    hs_p_d  = hs_q;
    vs_p_d  = vs_q;

    hc_d      = inc_x(hc_q);
    hsc_d     = hs_q ? inc_x(hsc_q) : hsc_q;
    bc_d      = blank_q ? inc_x(bc_q) : bc_q;
    ht_line_d = ht_line_q;
    hs_line_d = hs_line_q;
    ha_line_d = ha_line_q;
    if (hs_lead) begin
      ht_line_d = hc_q;
      hs_line_d = hsc_q;
      // Blanked lines (porches, sync) would otherwise report an active width of zero.
      if (bc_q != '0) ha_line_d = bc_q;
      hc_d  = {{(XW-1){1'b0}}, 1'b1};
      hsc_d = {{(XW-1){1'b0}}, 1'b1};
      bc_d  = {{(XW-1){1'b0}}, blank_q};
    end

    line_vs_d  = hs_lead ? vs_q    : (line_vs_q  | vs_q);
    line_act_d = hs_lead ? blank_q : (line_act_q | blank_q);
    vc_d       = vs_lead ? '0 : vc_n;
    vsc_d      = vs_lead ? '0 : vsc_n;
    ay_d       = vs_lead ? '0 : ay_n;
    frame_cnt_d = vs_lead ? frame_cnt_q + 16'd1 : frame_cnt_q;

    state_d    = state_q;
    stored_d   = stored_q;
    commit_d   = commit_q;
    locked_d   = locked_q;
    lock_err_d = lock_err_q;
    if (vs_lead) begin
      case (state_q)
        StSearch:  state_d = StMeasure;
        StMeasure: begin
          stored_d = meas;
          state_d  = StVerify;
        end
        StVerify: begin
          if (meas == stored_q) begin
            commit_d = meas;
            locked_d = 1'b1;
            state_d  = StLocked;
          end else begin
            stored_d = meas;
          end
        end
        StLocked: begin
          if (meas != commit_q) begin
            locked_d   = 1'b0;
            lock_err_d = (lock_err_q == 8'hFF) ? lock_err_q : lock_err_q + 8'd1;
            stored_d   = meas;
            state_d    = StVerify;
          end
        end
        default: state_d = StSearch;
      endcase
    end

    cap_valid_d = hit;
    cap_data_d  = hit ? rgb_q : cap_data_q;
    cap_err_d   = pend_q && locked_q && !locked_d && !hit;
    pend_d      = pend_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    if (req_q) begin
      pend_d = 1'b1;
      cx_d   = req_x_q;
      cy_d   = req_y_q;
    end else if (hit || cap_err_d) begin
      pend_d = 1'b0;
    end

`ifdef VGA_RX_CHECKSUM_EN
    pix_add = blank_q ? {8'h00, rgb_q} : 32'h0;
    sum_d   = vs_lead ? pix_add : sum_q + pix_add;
    fsum_d  = vs_lead ? sum_q : fsum_q;
    fsv_d   = vs_lead;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b0;  vs_q <= 1'b0;  blank_q <= 1'b0;  rgb_q <= '0;
      hs_p_q <= 1'b0;  vs_p_q <= 1'b0;
      req_q <= 1'b0;  req_x_q <= '0;  req_y_q <= '0;
      hc_q <= '0;  hsc_q <= '0;  bc_q <= '0;
      ht_line_q <= '0;  hs_line_q <= '0;  ha_line_q <= '0;
      vc_q <= '0;  vsc_q <= '0;  ay_q <= '0;
      line_vs_q <= 1'b0;  line_act_q <= 1'b0;
      frame_cnt_q <= '0;
      state_q <= StSearch;
      stored_q <= '0;  commit_q <= '0;
      locked_q <= 1'b0;  lock_err_q <= '0;
      pend_q <= 1'b0;  cx_q <= '0;  cy_q <= '0;
      cap_valid_q <= 1'b0;  cap_err_q <= 1'b0;  cap_data_q <= '0;
`ifdef VGA_RX_CHECKSUM_EN
      sum_q <= '0;  fsum_q <= '0;  fsv_q <= 1'b0;
`endif
    end else begin
      hs_q <= hs_d;  vs_q <= vs_d;  blank_q <= blank_d;  rgb_q <= rgb_d;
      hs_p_q <= hs_p_d;  vs_p_q <= vs_p_d;
      req_q <= req_d;  req_x_q <= req_x_d;  req_y_q <= req_y_d;
      hc_q <= hc_d;  hsc_q <= hsc_d;  bc_q <= bc_d;
      ht_line_q <= ht_line_d;  hs_line_q <= hs_line_d;  ha_line_q <= ha_line_d;
      vc_q <= vc_d;  vsc_q <= vsc_d;  ay_q <= ay_d;
      line_vs_q <= line_vs_d;  line_act_q <= line_act_d;
      frame_cnt_q <= frame_cnt_d;
      state_q <= state_d;
      stored_q <= stored_d;  commit_q <= commit_d;
      locked_q <= locked_d;  lock_err_q <= lock_err_d;
      pend_q <= pend_d;  cx_q <= cx_d;  cy_q <= cy_d;
      cap_valid_q <= cap_valid_d;  cap_err_q <= cap_err_d;  cap_data_q <= cap_data_d;
`ifdef VGA_RX_CHECKSUM_EN
      sum_q <= sum_d;  fsum_q <= fsum_d;  fsv_q <= fsv_d;
`endif
    end
  end

  assign h_total      = commit_q.ht;
  assign h_sync       = commit_q.hs;
  assign h_active     = commit_q.ha;
  assign v_total      = commit_q.vt;
  assign v_sync       = commit_q.vs;
  assign v_active     = commit_q.va;
  assign locked       = locked_q;
  assign lock_err_cnt = lock_err_q;
  assign frame_cnt    = frame_cnt_q;
  assign cap_valid    = cap_valid_q;
  assign cap_data     = cap_data_q;
  assign cap_err      = cap_err_q;
`ifdef VGA_RX_CHECKSUM_EN
  assign frame_sum       = fsum_q;
  assign frame_sum_valid = fsv_q;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor: geometry table plus capture, lock-loss and reset sequences.
module tb_vga_rx_monitor;
  localparam int XW = 12;
  localparam int YW = 11;

  logic          clock, reset;
  logic          vga_hs, vga_vs, vga_blank_n;
  logic [23:0]   vga_rgb;
  logic [XW-1:0] h_total, h_sync, h_active, cap_x;
  logic [YW-1:0] v_total, v_sync, v_active, cap_y;
  logic          locked, cap_req, cap_valid, cap_err;
  logic [7:0]    lock_err_cnt;
  logic [15:0]   frame_cnt;
  logic [23:0]   cap_data;
`ifdef VGA_RX_CHECKSUM_EN
  logic [31:0]   frame_sum;
  logic          frame_sum_valid;
`endif

  vga_rx_monitor #(
    .HS_ACTIVE_LOW(1'b1),
    .VS_ACTIVE_LOW(1'b0),
    .XW(XW),
    .YW(YW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_rgb(vga_rgb),
    .h_total(h_total),
    .h_sync(h_sync),
    .h_active(h_active),
    .v_total(v_total),
    .v_sync(v_sync),
    .v_active(v_active),
    .locked(locked),
    .lock_err_cnt(lock_err_cnt),
    .frame_cnt(frame_cnt),
`ifdef VGA_RX_CHECKSUM_EN
    .frame_sum(frame_sum),
    .frame_sum_valid(frame_sum_valid),
`endif
    .cap_x(cap_x),
    .cap_y(cap_y),
    .cap_req(cap_req),
    .cap_valid(cap_valid),
    .cap_data(cap_data),
    .cap_err(cap_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Pulse monitor, sampled away from the active edge.
  int          n_valid = 0, n_err = 0, n_err_misaligned = 0, n_fsv = 0;
  logic [23:0] last_cap = '0;
  logic [31:0] last_fsum = '0;
  logic        prev_locked = 1'b0;
  always @(negedge clock) begin
    if (cap_valid) begin
      n_valid  = n_valid + 1;
      last_cap = cap_data;
    end
    if (cap_err) begin
      n_err = n_err + 1;
      if (!(prev_locked && !locked)) n_err_misaligned = n_err_misaligned + 1;
    end
`ifdef VGA_RX_CHECKSUM_EN
    if (frame_sum_valid) begin
      n_fsv     = n_fsv + 1;
      last_fsum = frame_sum;
    end
`endif
    prev_locked = locked;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    vga_hs = 1'b1; vga_vs = 1'b0; vga_blank_n = 1'b0; vga_rgb = '0;
    cap_req = 1'b0; cap_x = '0; cap_y = '0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
  endtask

  // Frame starts with hs and vs asserting together; pixel = {0,y,x} unless cst is set.
  task automatic drive_frame(input int hsw, input int hbp, input int hact, input int hfp,
                             input int vsw, input int vbp, input int vact, input int vfp,
                             input bit cst, input bit req, input int rx, input int ry);
    int ht, vt, y, x;
    bit act, en;
    ht = hsw + hbp + hact + hfp;
    vt = vsw + vbp + vact + vfp;
    y  = 0;
    for (int l = 0; l < vt; l++) begin
      act = (l >= vsw + vbp) && (l < vsw + vbp + vact);
      for (int c = 0; c < ht; c++) begin
        x  = c - hsw - hbp;
        en = act && (c >= hsw + hbp) && (c < hsw + hbp + hact);
        vga_hs      = !(c < hsw);
        vga_vs      = (l < vsw);
        vga_blank_n = en;
        vga_rgb     = !en ? 24'h0 : (cst ? 24'h010203 : {8'h00, y[7:0], x[7:0]});
        cap_req     = req && (l == 0) && (c == 0);
        cap_x       = XW'(rx);
        cap_y       = YW'(ry);
        tick();
      end
      if (act) y = y + 1;
    end
  endtask

  task automatic small_frame(input int hact, input int hfp, input bit req, input int rx,
                             input int ry);
    drive_frame(2, 2, hact, hfp, 1, 1, 8, 1, 1'b0, req, rx, ry);
  endtask

  typedef struct {
    string name;
    int hsw, hbp, hact, hfp, vsw, vbp, vact, vfp;
    int ht, hs, ha, vt, vs, va;
  } vec_t;

  vec_t vecs[3];
  int   v0, e0;

  initial begin
    reset = 1'b0;
    idle();
    vecs[0] = '{"w1280", 136, 216, 1280, 80, 3, 1, 2, 1, 1712, 136, 1280, 7, 3, 2};
    vecs[1] = '{"h960", 1, 1, 3, 1, 3, 30, 960, 1, 6, 1, 3, 994, 3, 960};
    vecs[2] = '{"s16x8", 2, 2, 16, 4, 1, 1, 8, 1, 24, 2, 16, 11, 1, 8};

    apply_reset();
    check("reset_locked", locked, 0);
    check("reset_frame_cnt", frame_cnt, 0);

    foreach (vecs[i]) begin
      apply_reset();
      for (int f = 0; f < 3; f++) begin
        drive_frame(vecs[i].hsw, vecs[i].hbp, vecs[i].hact, vecs[i].hfp,
                    vecs[i].vsw, vecs[i].vbp, vecs[i].vact, vecs[i].vfp, 1'b0, 1'b0, 0, 0);
        if (f == 1) check({vecs[i].name, "_unlocked_after_2"}, locked, 0);
      end
      check({vecs[i].name, "_locked"}, locked, 1);
      check({vecs[i].name, "_h_total"}, h_total, vecs[i].ht);
      check({vecs[i].name, "_h_sync"}, h_sync, vecs[i].hs);
      check({vecs[i].name, "_h_active"}, h_active, vecs[i].ha);
      check({vecs[i].name, "_v_total"}, v_total, vecs[i].vt);
      check({vecs[i].name, "_v_sync"}, v_sync, vecs[i].vs);
      check({vecs[i].name, "_v_active"}, v_active, vecs[i].va);
      check({vecs[i].name, "_frame_cnt"}, frame_cnt, 3);
    end

    // Capture, out-of-range request, cancel on lock loss, relock.
    apply_reset();
    repeat (3) small_frame(16, 4, 1'b0, 0, 0);
    check("cap_pre_locked", locked, 1);
    v0 = n_valid;
    e0 = n_err;
    small_frame(16, 4, 1'b1, 5, 3);
    check("cap_valid_count", n_valid - v0, 1);
    check("cap_data_pulse", last_cap, 24'h000305);
    check("cap_data_held", cap_data, 24'h000305);
    v0 = n_valid;
    small_frame(16, 4, 1'b1, 20, 3);
    small_frame(16, 4, 1'b0, 0, 0);
    check("cap_out_of_range", n_valid - v0, 0);
    check("still_locked", locked, 1);
    small_frame(15, 5, 1'b0, 0, 0);
    check("bad_frame_not_yet_seen", locked, 1);
    small_frame(16, 4, 1'b0, 0, 0);
    check("lock_lost", locked, 0);
    check("lock_err_cnt", lock_err_cnt, 1);
    check("cap_err_count", n_err - e0, 1);
    check("cap_err_on_lock_fall", n_err_misaligned, 0);
    check("no_cap_valid_on_cancel", n_valid - v0, 0);
    check("h_active_held", h_active, 16);
    small_frame(16, 4, 1'b0, 0, 0);
    check("relock_pending", locked, 0);
    small_frame(16, 4, 1'b0, 0, 0);
    check("relocked", locked, 1);
    check("frame_cnt_10", frame_cnt, 10);

    // Asynchronous reset in the middle of an active line.
    vga_hs = 1'b1; vga_vs = 1'b0; vga_blank_n = 1'b1; vga_rgb = 24'h123456;
    repeat (7) tick();
    #2 reset = 1'b1;
    #1;
    check("rst_locked", locked, 0);
    check("rst_h_total", h_total, 0);
    check("rst_v_active", v_active, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_lock_err", lock_err_cnt, 0);
    check("rst_cap_data", cap_data, 0);
    tick();
    idle();
    reset = 1'b0;
    repeat (3) tick();
    repeat (2) small_frame(16, 4, 1'b0, 0, 0);
    check("rst_unlocked_after_2", locked, 0);
    small_frame(16, 4, 1'b0, 0, 0);
    check("rst_locked_after_3", locked, 1);

`ifdef VGA_RX_CHECKSUM_EN
    apply_reset();
    e0 = n_fsv;
    repeat (2) drive_frame(2, 2, 16, 4, 1, 1, 8, 1, 1'b1, 1'b0, 0, 0);
    check("sum_strobes", n_fsv - e0, 2);
    check("frame_sum", last_fsum, 32'h0081_0180);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_rx_monitor.md
# vga_rx_monitor

Receive-side companion to the VGA output peripheral: samples a VGA-style stream (HS, VS, BLANK_N, 24-bit {B,G,R}) on the pixel clock, recovers line/frame geometry, declares lock once two consecutive frames agree, and captures single pixels by active-area coordinate. It is used in loopback tests and on-board self-check to prove the controller emits the configured timing and vram/palette contents.

## Interface
Parameters:
- HS_ACTIVE_LOW, default 1: HS input asserted when low.
- VS_ACTIVE_LOW, default 0: VS input asserted when low (default matches the active-high VS our output peripheral drives).
- XW, default 12: width of horizontal counters, in pixel clocks.
- YW, default 11: width of vertical counters, in lines.

Ports (all synchronous to `clock`, except the asynchronous assertion of `reset`):
- clock  in  1  pixel clock, the same clock that drives the VGA outputs.
- reset  in  1  asynchronous, active-high reset.
- vga_hs  in  1  horizontal sync.
- vga_vs  in  1  vertical sync.
- vga_blank_n  in  1  high during active pixels.
- vga_rgb  in  24  {B[7:0],G[7:0],R[7:0]}.
- h_total, h_sync, h_active  out  XW  committed horizontal geometry.
- v_total, v_sync, v_active  out  YW  committed vertical geometry.
- locked  out  1  geometry stable.
- lock_err_cnt  out  8  number of lock losses, saturating.
- frame_cnt  out  16  number of vsync leading edges seen, wrapping.
- cap_x  in  XW  active-area x coordinate to capture.
- cap_y  in  YW  active-area y coordinate to capture.
- cap_req  in  1  one-cycle pulse that arms a capture.
- cap_valid  out  1  one-cycle pulse; cap_data is valid.
- cap_data  out  24  captured pixel.
- cap_err  out  1  one-cycle pulse; pending capture cancelled.

## Operation
- **Input stage:** all inputs pass through one register stage. Polarity is normalised to `hs_a`/`vs_a` (1 = asserted). Leading and trailing edges are detected against the previous registered sample.
- **Horizontal counters:** `hc` counts clocks since the last hs leading edge. Per line the block also counts hs-asserted clocks and blank_n=1 clocks. On each hs leading edge, the line values are latched as line totals and the counters restart at 1. All counters saturate at 2^XW-1.
- **Vertical counters:** line, vs-asserted and active-line counts advance on hs leading edges. A line is active if it contains at least one blank_n=1 sample. Counters saturate at 2^YW-1.
- **Frame boundary:** the vs leading edge. At each boundary, frame_cnt increments and the frame's measured six-tuple is handed to the FSM.
- **FSM states:**
  - SEARCH: waits for the first boundary, then goes to MEASURE.
  - MEASURE: at the next boundary, stores the tuple and goes to VERIFY.
  - VERIFY: at the next boundary, compares the new tuple to the stored one. Equal: commit the tuple to the outputs, set locked, go to LOCKED. Unequal: store the new tuple and stay in VERIFY.
  - LOCKED: at every boundary, compares against the committed tuple. Mismatch: clear locked, increment lock_err_cnt, store the new tuple, go to VERIFY.
  - The committed outputs hold their last values while unlocked.
- **Active coordinates:** `ax` counts blank_n=1 samples within a line and resets on the hs leading edge. `ay` counts active lines within a frame and resets at the frame boundary.
- **Capture handshake:**
  - cap_req latches cap_x/cap_y and sets `pending`. A new cap_req while pending replaces the coordinates.
  - When pending, locked, and the sample has blank_n=1 with (ax,ay) equal to the latched coordinates: cap_data takes vga_rgb, cap_valid pulses, and pending clears.
  - If pending and locked falls, cap_err pulses and pending clears.
  - If pending is set while unlocked, it waits for lock.
  - Coordinates outside h_active/v_active never match; the request stays pending until replaced.
  - cap_req and a match in the same cycle: the match completes using the old coordinates, then the new request becomes pending.
- **Reset:** asynchronous. All outputs are 0, the FSM is in SEARCH, pending is 0 and all counters are 0.

## Timing
- Input-to-internal latency is 1 clock.
- Committed geometry, locked, lock_err_cnt and frame_cnt update 2 clocks after the vs edge appears on the pins.
- cap_valid and cap_data assert 2 clocks after the matching pixel is on the pins.
- cap_err asserts on the same clock that locked falls.
- hs and vs leading edges in the same sample: the line ends first (line totals latched and the line counted), then the frame boundary is taken.

## Configuration
- `VGA_RX_CHECKSUM_EN`
  - Defined: adds output `frame_sum` (32 bits), the wrapping 32-bit sum of the zero-extended vga_rgb over all blank_n=1 samples in a frame, with its own strobe. At each frame boundary the sum latches into `frame_sum` and `frame_sum_valid` pulses for 1 clock; the accumulator then restarts. Reset value is 0.
  - Undefined: the port and accumulator are absent, and all other behaviour is identical.

## Test plan
- **Lock at 1280x960:** drive 1280x960 timing (sync/back/active/front of 136/216/1280/80 clocks and 3/30/960/1 lines, HS active-low, VS active-high) for 3 frames. Required: locked=1 after the third boundary; h_total=1712, h_sync=136, h_active=1280, v_total=994, v_sync=3, v_active=960.
- **Lock loss and relock:** small 16x8 frame locked, then one frame with h_active=15. Required: locked=0 and lock_err_cnt=1; relocks after two good frames.
- **Capture:** locked 16x8 with pixel = {8'h00, y, x}; cap_req at (5,3). Required: one cap_valid with cap_data=24'h000305. Coordinates (20,3) → no cap_valid for 2 frames.
- **Capture cancel:** pending request, then the geometry is corrupted. Required: cap_err pulses on the clock locked falls; no cap_valid.
- **Reset mid-frame:** assert reset mid-line. Required: all outputs 0 immediately and SEARCH. After release, lock needs 3 boundaries.
- **Checksum (with `VGA_RX_CHECKSUM_EN`):** 16x8 frame of constant 24'h010203. Required: frame_sum=128×66051=32'h0081_0180.
